uart_frame_parser: RTL and testbench
====================================

# uart_frame_parser

Byte-stream framing stage directly downstream of the UART receiver. It consumes the receiver's per-byte completion pulse and data byte and recognises command frames of the form 0x55 0xAA CMD LEN PAYLOAD[LEN] CHK. It validates each frame's length and checksum and buffers the payload. Each good frame is presented to the command-handling logic through a valid/ack handshake, with error pulses and a dropped-byte counter for diagnostics.

## Interface
Parameters:
- MAX_LEN, 16, maximum payload bytes accepted; legal range 1..16.
- TIMEOUT_CYC, 50000, inter-byte timeout in sys_clk cycles (1 ms at 50 MHz); legal range 2..2^20.

Ports (one clock; reset is asynchronous and active-high):
- sys_clk  input  1  system clock.
- sys_rst  input  1  asynchronous, active-high reset.
- uart_done  input  1  one-cycle pulse: uart_data holds a newly received byte.
- uart_data  input  8  received byte; sampled only when uart_done=1.
- cmd_valid  output  1  good frame available; held until accepted.
- cmd_ack  input  1  consumer accepts the frame; meaningful only while cmd_valid=1.
- cmd_code  output  8  CMD byte of the held frame.
- cmd_len  output  5  LEN of the held frame, 0..MAX_LEN.
- pl_addr  input  4  payload buffer read index.
- pl_data  output  8  payload byte at pl_addr; registered, 1-cycle read latency.
- chk_err  output  1  one-cycle pulse: checksum mismatch.
- len_err  output  1  one-cycle pulse: LEN > MAX_LEN.
- to_err  output  1  one-cycle pulse: inter-byte timeout mid-frame.
- drop_cnt  output  8  bytes discarded while a frame was held; saturates at 255.

## Operation
- FSM states: IDLE, HDR2, CMD, LEN, DATA, CHK, HOLD. All transitions except HOLD exit and timeout occur only on cycles where uart_done=1.
- IDLE:
  - 0x55 -> HDR2.
  - Any other byte is ignored.
- HDR2:
  - 0xAA -> CMD.
  - 0x55 -> stay in HDR2 (resync).
  - Any other byte -> IDLE.
- CMD: latch the byte into the code register; checksum accumulator = byte; -> LEN.
- LEN:
  - Latch the length; accumulator += byte.
  - LEN > MAX_LEN -> pulse len_err, go to IDLE.
  - LEN = 0 -> CHK.
  - Otherwise -> DATA with index = 0.
- DATA:
  - Write byte to buffer[index]; accumulator += byte; index++.
  - When index reaches LEN-1 on this write -> CHK.
- CHK:
  - byte == accumulator (8-bit, mod 256) -> HOLD, and assert cmd_valid.
  - Mismatch -> pulse chk_err, go to IDLE.
- HOLD:
  - cmd_valid=1; cmd_code, cmd_len and the buffer contents are frozen.
  - Every uart_done while in HOLD, including the cmd_ack cycle, discards the byte and increments drop_cnt (saturating).
  - cmd_ack=1 -> cmd_valid=0 next cycle, -> IDLE.
- Timeout counter (20-bit):
  - Cleared on every uart_done and in IDLE and HOLD.
  - Otherwise increments each cycle.
  - On reaching TIMEOUT_CYC-1 in HDR2..CHK -> pulse to_err, go to IDLE.
  - If uart_done arrives in the same cycle, the byte wins and the timeout does not fire.
- The buffer is a MAX_LEN x 8 register array. pl_data = buffer[pl_addr] registered. pl_addr >= MAX_LEN reads 0x00.
- A rejected frame leaves the code and length registers unspecified; partially overwritten buffer contents are legal because they are only read while cmd_valid=1.

## Timing
- Reset values: cmd_valid=0, cmd_code=0x00, cmd_len=0, pl_data=0x00, chk_err=len_err=to_err=0, drop_cnt=0, buffer all 0x00, FSM=IDLE, accumulator and timeout counter 0.
- sys_rst asserted mid-frame or in HOLD: immediate return to reset values. Any pending frame is lost without an error pulse.
- cmd_valid rises on the cycle after the uart_done carrying a correct CHK byte.
- chk_err and len_err pulse on the cycle after the offending byte's uart_done.
- to_err pulses on the cycle after the counter reaches TIMEOUT_CYC-1. Exactly one error pulse per rejected frame.
- cmd_ack in cycle N drops cmd_valid in N+1. The FSM accepts 0x55 from cycle N+1 onward.
- Back-to-back uart_done on consecutive cycles must be handled; the UART never produces this, but the bench does.
- pl_data reflects pl_addr sampled one cycle earlier.

## Test plan
- Good frame: 55 AA 01 02 12 34 49 -> cmd_valid one cycle after the 0x49 pulse; cmd_code=0x01, cmd_len=2; pl_addr 0/1 -> pl_data 0x12/0x34; cmd_ack -> cmd_valid=0 next cycle.
- Bad checksum: 55 AA 01 02 12 34 48 -> chk_err single pulse, cmd_valid stays 0. A following good frame is accepted.
- Length and zero length:
  - 55 AA 07 11 -> len_err pulse, FSM back in IDLE.
  - 55 AA 07 00 07 -> cmd_valid with cmd_len=0.
- Resync and timeout:
  - 55 55 AA 02 00 02 -> accepted with cmd_code=0x02.
  - 55 AA 03, then TIMEOUT_CYC idle cycles -> to_err pulse. A subsequent good frame is accepted.
- Hold and drop:
  - With a frame held, send 300 bytes -> drop_cnt=255 (saturated), frame contents unchanged.
  - cmd_ack coincident with uart_done -> byte dropped, FSM in IDLE.
- Reset mid-DATA: assert sys_rst after 55 AA 01 04 10 -> all outputs at reset values. The next full good frame is accepted.

Source files
------------

// File: rtl/uart_frame_parser_if.sv
// uart_frame_parser_if
// Groups the byte input, the command handshake, the payload read port and
// the diagnostic outputs of uart_frame_parser into one bundle.
//   uart_done/uart_data : byte strobe and data from the UART receiver
//   cmd_valid/cmd_ack   : frame-available / frame-accepted handshake
//   cmd_code/cmd_len    : CMD and LEN of the held frame
//   pl_addr/pl_data     : payload read index and registered read data
//   chk_err/len_err/to_err : one-cycle error pulses
//   drop_cnt            : saturating count of bytes dropped while holding
// The slave modport is the parser; the master modport is its surroundings
// (UART receiver plus command handler).
interface uart_frame_parser_if;
    logic       uart_done;
    logic [7:0] uart_data;
    logic       cmd_valid;
    logic       cmd_ack;
    logic [7:0] cmd_code;
    logic [4:0] cmd_len;
    logic [3:0] pl_addr;
    logic [7:0] pl_data;
    logic       chk_err;
    logic       len_err;
    logic       to_err;
    logic [7:0] drop_cnt;

    modport master (
        output uart_done, uart_data, cmd_ack, pl_addr,
        input  cmd_valid, cmd_code, cmd_len, pl_data,
        input  chk_err, len_err, to_err, drop_cnt
    );

    modport slave (
        input  uart_done, uart_data, cmd_ack, pl_addr,
        output cmd_valid, cmd_code, cmd_len, pl_data,
        output chk_err, len_err, to_err, drop_cnt
    );
endinterface

// File: rtl/uart_frame_parser.sv
// uart_frame_parser
// Recognises frames 0x55 0xAA CMD LEN PAYLOAD[LEN] CHK in the UART byte
// stream, checks LEN against MAX_LEN and CHK against the mod-256 sum of
// CMD, LEN and the payload, buffers the payload and holds each good frame
// until the consumer acknowledges it.
// Ports:
//   sys_clk : system clock
//   sys_rst : asynchronous, active-high reset
//   bus     : uart_frame_parser_if slave modport (byte input, command
//             handshake, payload read port, error pulses, drop counter)
// Parameters:
//   MAX_LEN     : largest accepted payload, 1..16
//   TIMEOUT_CYC : inter-byte timeout in sys_clk cycles, 2..2^20
module uart_frame_parser #(
    parameter int MAX_LEN     = 16,
    parameter int TIMEOUT_CYC = 50000
) (
    input logic                sys_clk,
    input logic                sys_rst,
    uart_frame_parser_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        HDR2,
        CMD,
        LEN,
        DATA,
        CHK,
        HOLD
    } state_t;

    state_t      state;
    logic [7:0]  buffer [MAX_LEN];
    logic [7:0]  acc;
    logic [3:0]  idx;
    logic [19:0] to_cnt;
    logic        in_frame;
    logic        to_hit;

    // A frame is "in flight" from the first header byte up to the checksum.
    // A byte arriving in the expiry cycle takes priority over the timeout.
    assign in_frame = (state != IDLE) && (state != HOLD);
    assign to_hit   = in_frame && !bus.uart_done &&
                      (to_cnt == 20'(TIMEOUT_CYC - 1));

    // Frame FSM with all of its registered outputs. The timeout counter is
    // kept here too so that it restarts on the same edge the FSM leaves a
    // frame, and the error pulses default low every cycle.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state         <= IDLE;
            acc           <= 8'h00;
            idx           <= 4'd0;
            to_cnt        <= 20'd0;
            bus.cmd_valid <= 1'b0;
            bus.cmd_code  <= 8'h00;
            bus.cmd_len   <= 5'd0;
            bus.chk_err   <= 1'b0;
            bus.len_err   <= 1'b0;
            bus.to_err    <= 1'b0;
            bus.drop_cnt  <= 8'h00;
            for (int i = 0; i < MAX_LEN; i++) begin
                buffer[i] <= 8'h00;
            end
        end else begin
            bus.chk_err <= 1'b0;
            bus.len_err <= 1'b0;
            bus.to_err  <= 1'b0;

            if (bus.uart_done || !in_frame || to_hit) begin
                to_cnt <= 20'd0;
            end else begin
                to_cnt <= to_cnt + 20'd1;
            end

            if (to_hit) begin
                bus.to_err <= 1'b1;
                state      <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.uart_done && bus.uart_data == 8'h55) begin
                            state <= HDR2;
                        end
                    end
                    HDR2: begin
                        // A repeated 0x55 may be the real start of a frame.
                        if (bus.uart_done) begin
                            if (bus.uart_data == 8'hAA) begin
                                state <= CMD;
                            end else if (bus.uart_data != 8'h55) begin
                                state <= IDLE;
                            end
                        end
                    end
                    CMD: begin
                        if (bus.uart_done) begin
                            bus.cmd_code <= bus.uart_data;
                            acc          <= bus.uart_data;
                            state        <= LEN;
                        end
                    end
                    LEN: begin
                        if (bus.uart_done) begin
                            bus.cmd_len <= bus.uart_data[4:0];
                            acc         <= acc + bus.uart_data;
                            idx         <= 4'd0;
                            if (int'(bus.uart_data) > MAX_LEN) begin
                                bus.len_err <= 1'b1;
                                state       <= IDLE;
                            end else if (bus.uart_data == 8'h00) begin
                                state <= CHK;
                            end else begin
                                state <= DATA;
                            end
                        end
                    end
                    DATA: begin
                        if (bus.uart_done) begin
                            buffer[idx] <= bus.uart_data;
                            acc         <= acc + bus.uart_data;
                            if (5'(idx) == bus.cmd_len - 5'd1) begin
                                state <= CHK;
                            end else begin
                                idx <= idx + 4'd1;
                            end
                        end
                    end
                    CHK: begin
                        if (bus.uart_done) begin
                            if (bus.uart_data == acc) begin
                                bus.cmd_valid <= 1'b1;
                                state         <= HOLD;
                            end else begin
                                bus.chk_err <= 1'b1;
                                state       <= IDLE;
                            end
                        end
                    end
                    HOLD: begin
                        // Frame is frozen; incoming bytes are only counted,
                        // including one arriving together with the ack.
                        if (bus.uart_done && bus.drop_cnt != 8'hFF) begin
                            bus.drop_cnt <= bus.drop_cnt + 8'd1;
                        end
                        if (bus.cmd_ack) begin
                            bus.cmd_valid <= 1'b0;
                            state         <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Registered payload read port. When the buffer is smaller than the
    // 4-bit address space, out-of-range addresses read as zero.
    generate
        if (MAX_LEN < 16) begin : g_partial_buf
            always_ff @(posedge sys_clk or posedge sys_rst) begin
                if (sys_rst) begin
                    bus.pl_data <= 8'h00;
                end else if ({1'b0, bus.pl_addr} < 5'(MAX_LEN)) begin
                    bus.pl_data <= buffer[bus.pl_addr];
                end else begin
                    bus.pl_data <= 8'h00;
                end
            end
        end else begin : g_full_buf
            always_ff @(posedge sys_clk or posedge sys_rst) begin
                if (sys_rst) begin
                    bus.pl_data <= 8'h00;
                end else begin
                    bus.pl_data <= buffer[bus.pl_addr];
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_uart_frame_parser.sv
// tb_uart_frame_parser
// Self-checking bench for uart_frame_parser. A queue-based frame model
// decides, byte by byte, what the parser must report; a compare process
// checks the DUT against it on every falling edge, and directed frames
// with hand-computed values pin the model itself.
`timescale 1ns/1ps
module tb_uart_frame_parser;

    localparam int MAX_LEN     = 16;
    localparam int TIMEOUT_CYC = 40;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;

    uart_frame_parser_if bus_if ();

    uart_frame_parser #(
        .MAX_LEN    (MAX_LEN),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .sys_clk(sys_clk),
        .sys_rst(sys_rst),
        .bus    (bus_if)
    );

    always #5 sys_clk = ~sys_clk;

    int total = 0;
    int bad   = 0;
    logic checking = 1'b0;

    // Reference model state: bytes of the frame in progress, held frame
    // contents, the buffer as written by payload bytes, expected pulses.
    byte unsigned q[$];
    logic [7:0]   m_mem [MAX_LEN];
    logic         m_held = 1'b0;
    logic [7:0]   m_code = 8'h00;
    logic [4:0]   m_len  = 5'd0;
    logic [7:0]   m_drop = 8'h00;
    logic         m_chk  = 1'b0;
    logic         m_lerr = 1'b0;
    logic         m_to   = 1'b0;
    logic [7:0]   m_pl   = 8'h00;
    int           cyc = 0;
    int           last_byte = 0;

    // Pulse counters of the DUT outputs for the directed "exactly one" checks.
    int chk_pulses = 0;
    int len_pulses = 0;
    int to_pulses  = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Feed one byte into the frame model.
    task automatic modelByte(input byte unsigned b);
        int n;
        int s;
        int l;
        q.push_back(b);
        n = q.size();
        if (n == 1) begin
            if (b != 8'h55) q.delete();
        end else if (n == 2) begin
            if (b == 8'h55) begin
                q.delete();
                q.push_back(8'h55);
            end else if (b != 8'hAA) begin
                q.delete();
            end
        end else if (n == 4) begin
            if (int'(b) > MAX_LEN) begin
                m_lerr = 1'b1;
                q.delete();
            end
        end else if (n >= 5) begin
            l = int'(q[3]);
            if (n < 5 + l) begin
                m_mem[n - 5] = b;
            end else begin
                s = 0;
                for (int i = 2; i < n - 1; i++) s += int'(q[i]);
                if (8'(s) == b) begin
                    m_held = 1'b1;
                    m_code = q[2];
                    m_len  = 5'(l);
                end else begin
                    m_chk = 1'b1;
                end
                q.delete();
            end
        end
    endtask

    // Model clock: evaluates what the DUT outputs must be after each edge.
    initial begin
        foreach (m_mem[i]) m_mem[i] = 8'h00;
        forever begin
            @(posedge sys_clk or posedge sys_rst);
            if (sys_rst) begin
                q.delete();
                foreach (m_mem[i]) m_mem[i] = 8'h00;
                m_held = 1'b0; m_code = 8'h00; m_len = 5'd0; m_drop = 8'h00;
                m_chk = 1'b0; m_lerr = 1'b0; m_to = 1'b0; m_pl = 8'h00;
                cyc = 0; last_byte = 0;
            end else begin
                cyc++;
                m_chk = 1'b0; m_lerr = 1'b0; m_to = 1'b0;
                m_pl = (int'(bus_if.pl_addr) < MAX_LEN) ? m_mem[bus_if.pl_addr] : 8'h00;
                if (m_held) begin
                    if (bus_if.uart_done && m_drop != 8'hFF) m_drop = m_drop + 8'd1;
                    if (bus_if.cmd_ack) m_held = 1'b0;
                end else if (bus_if.uart_done) begin
                    last_byte = cyc;
                    modelByte(bus_if.uart_data);
                end else if (q.size() > 0 && cyc - last_byte == TIMEOUT_CYC) begin
                    m_to = 1'b1;
                    q.delete();
                end
            end
        end
    end

    // Single compare process against the model.
    initial begin
        forever begin
            @(negedge sys_clk);
            if (checking) begin
                checkOutput("cmd_valid", 32'(bus_if.cmd_valid), 32'(m_held));
                checkOutput("chk_err",   32'(bus_if.chk_err),   32'(m_chk));
                checkOutput("len_err",   32'(bus_if.len_err),   32'(m_lerr));
                checkOutput("to_err",    32'(bus_if.to_err),    32'(m_to));
                checkOutput("drop_cnt",  32'(bus_if.drop_cnt),  32'(m_drop));
                if (m_held) begin
                    checkOutput("cmd_code", 32'(bus_if.cmd_code), 32'(m_code));
                    checkOutput("cmd_len",  32'(bus_if.cmd_len),  32'(m_len));
                    checkOutput("pl_data",  32'(bus_if.pl_data),  32'(m_pl));
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge sys_clk);
            if (bus_if.chk_err) chk_pulses++;
            if (bus_if.len_err) len_pulses++;
            if (bus_if.to_err)  to_pulses++;
        end
    end

    // One byte strobe; entered and left just after a falling edge.
    task automatic applyStimulus(input logic [7:0] b);
        bus_if.uart_done = 1'b1;
        bus_if.uart_data = b;
        @(negedge sys_clk);
        bus_if.uart_done = 1'b0;
    endtask

    task automatic sendFrame(input byte unsigned frm[$]);
        foreach (frm[i]) applyStimulus(frm[i]);
    endtask

    task automatic readPayload(input string name, input logic [3:0] addr,
                               input logic [7:0] expected);
        bus_if.pl_addr = addr;
        @(negedge sys_clk);
        checkOutput(name, 32'(bus_if.pl_data), 32'(expected));
    endtask

    task automatic doAck();
        bus_if.cmd_ack = 1'b1;
        @(negedge sys_clk);
        bus_if.cmd_ack = 1'b0;
        checkOutput("ack_clears_valid", 32'(bus_if.cmd_valid), 32'd0);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_valid"}, 32'(bus_if.cmd_valid), 32'd0);
        checkOutput({tag, "_code"},  32'(bus_if.cmd_code),  32'd0);
        checkOutput({tag, "_len"},   32'(bus_if.cmd_len),   32'd0);
        checkOutput({tag, "_pl"},    32'(bus_if.pl_data),   32'd0);
        checkOutput({tag, "_drop"},  32'(bus_if.drop_cnt),  32'd0);
        checkOutput({tag, "_errs"},
                    32'({bus_if.chk_err, bus_if.len_err, bus_if.to_err}), 32'd0);
    endtask

    // Hard stop if the bench ever stalls.
    initial begin
        #1000000;
        bad++;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    byte unsigned frm[$];
    int base;
    int waited;
    logic seen;

    initial begin
        bus_if.uart_done = 1'b0;
        bus_if.uart_data = 8'h00;
        bus_if.cmd_ack   = 1'b0;
        bus_if.pl_addr   = 4'd0;
        repeat (3) @(negedge sys_clk);
        checkResetState("reset");
        sys_rst  = 1'b0;
        checking = 1'b1;
        @(negedge sys_clk);

        $display("[TB] good frame");
        frm = '{8'h55, 8'hAA, 8'h01, 8'h02, 8'h12, 8'h34, 8'h49};
        sendFrame(frm);
        checkOutput("f1_valid", 32'(bus_if.cmd_valid), 32'd1);
        checkOutput("f1_code",  32'(bus_if.cmd_code),  32'h01);
        checkOutput("f1_len",   32'(bus_if.cmd_len),   32'd2);
        readPayload("f1_pl0", 4'd0, 8'h12);
        readPayload("f1_pl1", 4'd1, 8'h34);
        doAck();

        $display("[TB] bad checksum then good frame");
        base = chk_pulses;
        frm = '{8'h55, 8'hAA, 8'h01, 8'h02, 8'h12, 8'h34, 8'h48};
        sendFrame(frm);
        repeat (3) @(negedge sys_clk);
        checkOutput("chk_err_once", 32'(chk_pulses - base), 32'd1);
        checkOutput("chk_no_valid", 32'(bus_if.cmd_valid), 32'd0);
        frm = '{8'h55, 8'hAA, 8'h05, 8'h01, 8'h77, 8'h7D};
        sendFrame(frm);
        checkOutput("f2_code", 32'(bus_if.cmd_code), 32'h05);
        readPayload("f2_pl0", 4'd0, 8'h77);
        doAck();

        $display("[TB] length checks");
        base = len_pulses;
        frm = '{8'h55, 8'hAA, 8'h07, 8'h11};
        sendFrame(frm);
        repeat (3) @(negedge sys_clk);
        checkOutput("len_err_once", 32'(len_pulses - base), 32'd1);
        frm = '{8'h55, 8'hAA, 8'h07, 8'h00, 8'h07};
        sendFrame(frm);
        checkOutput("zlen_valid", 32'(bus_if.cmd_valid), 32'd1);
        checkOutput("zlen_len",   32'(bus_if.cmd_len),   32'd0);
        doAck();
        frm = '{8'h55, 8'hAA, 8'h10, 8'h10};
        for (int i = 1; i <= 16; i++) frm.push_back(8'(i));
        frm.push_back(8'hA8);
        sendFrame(frm);
        checkOutput("max_len", 32'(bus_if.cmd_len), 32'd16);
        readPayload("max_pl15", 4'd15, 8'h10);
        doAck();

        $display("[TB] resync and timeout");
        frm = '{8'h55, 8'h55, 8'hAA, 8'h02, 8'h00, 8'h02};
        sendFrame(frm);
        checkOutput("resync_code", 32'(bus_if.cmd_code), 32'h02);
        doAck();
        base = to_pulses;
        frm = '{8'h55, 8'hAA, 8'h03};
        sendFrame(frm);
        seen = 1'b0;
        waited = 0;
        while (!seen && waited < TIMEOUT_CYC + 20) begin
            @(negedge sys_clk);
            waited++;
            if (bus_if.to_err) seen = 1'b1;
        end
        checkOutput("to_err_seen", 32'(seen), 32'd1);
        checkOutput("to_err_delay", 32'(waited), 32'(TIMEOUT_CYC));
        repeat (3) @(negedge sys_clk);
        checkOutput("to_err_once", 32'(to_pulses - base), 32'd1);
        frm = '{8'h55, 8'hAA, 8'h01, 8'h02, 8'h12, 8'h34, 8'h49};
        sendFrame(frm);
        checkOutput("after_to_valid", 32'(bus_if.cmd_valid), 32'd1);

        $display("[TB] ack coincident with byte");
        bus_if.cmd_ack   = 1'b1;
        bus_if.uart_done = 1'b1;
        bus_if.uart_data = 8'h55;
        @(negedge sys_clk);
        bus_if.cmd_ack   = 1'b0;
        bus_if.uart_done = 1'b0;
        checkOutput("coinc_drop", 32'(bus_if.drop_cnt), 32'd1);
        frm = '{8'hAA, 8'h01, 8'h02, 8'h12, 8'h34, 8'h49};
        sendFrame(frm);
        repeat (2) @(negedge sys_clk);
        checkOutput("coinc_idle", 32'(bus_if.cmd_valid), 32'd0);

        $display("[TB] hold and drop saturation");
        frm = '{8'h55, 8'hAA, 8'h01, 8'h02, 8'h12, 8'h34, 8'h49};
        sendFrame(frm);
        for (int i = 0; i < 300; i++) applyStimulus(8'(i));
        checkOutput("drop_sat",   32'(bus_if.drop_cnt), 32'd255);
        checkOutput("hold_code",  32'(bus_if.cmd_code), 32'h01);
        checkOutput("hold_len",   32'(bus_if.cmd_len),  32'd2);
        readPayload("hold_pl0", 4'd0, 8'h12);
        readPayload("hold_pl1", 4'd1, 8'h34);

        $display("[TB] reset mid-DATA");
        doAck();
        frm = '{8'h55, 8'hAA, 8'h01, 8'h04, 8'h10};
        sendFrame(frm);
        #2 sys_rst = 1'b1;
        @(negedge sys_clk);
        checkResetState("midrst");
        sys_rst = 1'b0;
        @(negedge sys_clk);
        frm = '{8'h55, 8'hAA, 8'h01, 8'h02, 8'h12, 8'h34, 8'h49};
        sendFrame(frm);
        checkOutput("post_rst_valid", 32'(bus_if.cmd_valid), 32'd1);
        readPayload("post_rst_pl1", 4'd1, 8'h34);
        doAck();

        repeat (3) @(negedge sys_clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
